data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_if.sv | 23 ++
 rtl/data_mem_ctrl.sv | 153 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store unit and data_mem_ctrl.
// The master holds a request until it is accepted; the response is a one-cycle strobe.
interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-organised little-endian data memory serving RV32I loads and stores with fixed wait states.
// Out-of-range, misaligned and illegal-width requests are answered with an error strobe.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    data_mem_ctrl_if.slave bus,
    output logic           busy_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [AW-1:0] idx_q;
    logic [1:0]    off_q;
    logic [31:0]   wdata_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_rdata_q;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          req_err_d;
    logic          access_d;
    logic          mem_we_d;
    logic [3:0]    be_d;
    logic [31:0]   wlane_d;
    logic [31:0]   rword_d;
    logic [31:0]   rshift_d;
    logic [31:0]   load_d;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign busy_o        = (state_q != IDLE);
    assign access_d      = (state_q == WAIT) && (cnt_q == 4'd0);
    assign mem_we_d      = access_d && we_q;

    // Any single rule is enough to reject the request before it touches the array.
    always_comb begin
        req_err_d = 1'b0;
        if (bus.req_addr[31:AW+2] != '0) req_err_d = 1'b1;
        if (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 || bus.req_funct3 == 3'b111) req_err_d = 1'b1;
        if (bus.req_we && bus.req_funct3[2]) req_err_d = 1'b1;
        if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) req_err_d = 1'b1;
        if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) req_err_d = 1'b1;
    end

    // Store data is replicated across lanes so only the byte enables depend on the offset.
    always_comb begin
        be_d    = 4'b1111;
        wlane_d = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be_d    = 4'b0001 << off_q;
                wlane_d = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_d    = off_q[1] ? 4'b1100 : 4'b0011;
                wlane_d = {2{wdata_q[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wlane_d = wdata_q;
            end
        endcase
    end

    always_comb begin
        rword_d  = mem_q[idx_q];
        rshift_d = rword_d >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_d = {{24{rshift_d[7]}}, rshift_d[7:0]};
            3'b001:  load_d = {{16{rshift_d[15]}}, rshift_d[15:0]};
            3'b100:  load_d = {24'h0, rshift_d[7:0]};
            3'b101:  load_d = {16'h0, rshift_d[15:0]};
            default: load_d = rword_d;
        endcase
    end

    // The array has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (mem_we_d) begin
            for (int b = 0; b < 4; b++) begin
                if (be_d[b]) mem_q[idx_q][8*b +: 8] <= wlane_d[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            idx_q       <= '0;
            off_q       <= 2'b00;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        idx_q    <= bus.req_addr[AW+1:2];
                        off_q    <= bus.req_addr[1:0];
                        wdata_q  <= bus.req_wdata;
                        if (req_err_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(WAIT_STATES);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? 32'h0 : load_d;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios and randomized traffic
// compared against a byte-array reference memory.
module tb_data_mem_ctrl;
    localparam int DEPTH = 64;
    localparam int WS    = 2;
    localparam int NBYTE = 4 * DEPTH;

    localparam logic [2:0]  LANE_F3   [4] = '{3'b010, 3'b000, 3'b100, 3'b001};
    localparam logic [31:0] LANE_ADDR [4] = '{32'h10, 32'h11, 32'h11, 32'h12};
    localparam logic [31:0] LANE_EXP  [4] = '{32'hDEADA5EF, 32'hFFFFFFA5, 32'h000000A5, 32'hFFFFDEAD};

    localparam logic        ERR_WE   [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [2:0]  ERR_F3   [9] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100, 3'b111, 3'b110, 3'b101, 3'b010};
    localparam logic [31:0] ERR_ADDR [9] = '{32'h13, 32'h100, 32'h2, 32'h0, 32'h4, 32'h8, 32'h8, 32'h15, 32'hFFFFFFFC};

    localparam logic [2:0]  LEGAL_F3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;
    logic busy0;

    data_mem_ctrl_if m ();
    data_mem_ctrl_if m0 ();

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (m.slave),
        .busy_o(busy)
    );

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (m0.slave),
        .busy_o(busy0)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ref_mem [NBYTE];
    logic [31:0] r_data;
    logic        r_err;
    int          r_lat;
    int          r_stall;
    int          r_zero;
    logic        r_tail;
    logic [31:0] e_data;
    logic        e_err;

    // Reference memory works on individual bytes, independent of word organisation.
    task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
        int size;
        logic [31:0] v;
        err = (addr >= NBYTE) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
              (we && f3[2]) || (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        rdata = 32'h0;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[addr + i];
                if (!f3[2] && size < 4 && v[8*size-1]) begin
                    for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
                end
                rdata = v;
            end
        end
    endtask

    // Drives one request on the main port and measures stall, latency and the response.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat, output int stall,
                          output int zero_bad, output logic tail_ok);
        m.req_valid  = 1'b1;
        m.req_we     = we;
        m.req_funct3 = f3;
        m.req_addr   = addr;
        m.req_wdata  = wdata;
        stall = 0;
        while (m.req_ready !== 1'b1 && stall < 40) begin
            @(posedge clk); #1;
            stall++;
        end
        @(posedge clk); #1;
        m.req_valid = 1'b0;
        lat      = 0;
        zero_bad = 0;
        while (m.rsp_valid !== 1'b1 && lat < 40) begin
            if (m.rsp_rdata !== 32'h0) zero_bad++;
            @(posedge clk); #1;
            lat++;
        end
        rdata = m.rsp_rdata;
        err   = m.rsp_err;
        @(posedge clk); #1;
        tail_ok = (m.rsp_valid === 1'b0) && (m.rsp_rdata === 32'h0) && (m.req_ready === 1'b1);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        total++; if (m.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_rsp_valid: got %0b expected 0", m.rsp_valid); end
        total++; if (m.rsp_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_rsp_err: got %0b expected 0", m.rsp_err); end
        total++; if (m.rsp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_rsp_rdata: got %h expected 0", m.rsp_rdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %0b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (m.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready: got %0b expected 1", m.req_ready); end
        ref_access(1'b1, 3'b010, 32'h0, 32'h01020304, e_err, e_data);
        do_req(1'b1, 3'b010, 32'h0, 32'h01020304, r_data, r_err, r_lat, r_stall, r_zero, r_tail);
        total++; if (r_stall !== 0) begin bad++; $display("[TB] FAIL first_accept_stall: got %0d expected 0", r_stall); end
        total++; if (r_lat !== WS + 1) begin bad++; $display("[TB] FAIL first_latency: got %0d expected %0d", r_lat, WS + 1); end
    endtask

    task automatic preload();
        logic [31:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            ref_access(1'b1, 3'b010, 32'(4 * i), w, e_err, e_data);
            do_req(1'b1, 3'b010, 32'(4 * i), w, r_data, r_err, r_lat, r_stall, r_zero, r_tail);
        end
    endtask

    task automatic test_store_load();
        ref_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, e_err, e_data);
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r_data, r_err, r_lat, r_stall, r_zero, r_tail);
        total++; if (r_lat !== WS + 1) begin bad++; $display("[TB] FAIL sw_latency: got %0d expected %0d", r_lat, WS + 1); end
        total++; if (r_err !== 1'b0) begin bad++; $display("[TB] FAIL sw_err: got %0b expected 0", r_err); end
        total++; if (r_data !== 32'h0) begin bad++; $display("[TB] FAIL sw_rdata: got %h expected 0", r_data); end
        total++; if (r_tail !== 1'b1) begin bad++; $display("[TB] FAIL sw_one_cycle: got %0b expected 1", r_tail); end
        ref_access(1'b0, 3'b010, 32'h10, 32'h0, e_err, e_data);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, r_data, r_err, r_lat, r_stall, r_zero, r_tail);
        total++; if (r_lat !== WS + 1) begin bad++; $display("[TB] FAIL lw_latency: got %0d expected %0d", r_lat, WS + 1); end
        total++; if (r_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL lw_rdata: got %h expected deadbeef", r_data); end
        total++; if (r_err !== 1'b0) begin bad++; $display("[TB] FAIL lw_err: got %0b expected 0", r_err); end
        total++; if (r_zero !== 0) begin bad++; $display("[TB] FAIL lw_idle_rdata: got %0d nonzero cycles expected 0", r_zero); end
    endtask

    task automatic test_byte_lanes();
        ref_access(1'b1, 3'b000, 32'h11, 32'h000000A5, e_err, e_data);
        do_req(1'b1, 3'b000, 32'h11, 32'h000000A5, r_data, r_err, r_lat, r_stall, r_zero, r_tail);
        for (int i = 0; i < 4; i++) begin
            ref_access(1'b0, LANE_F3[i], LANE_ADDR[i], 32'h0, e_err, e_data);
            do_req(1'b0, LANE_F3[i], LANE_ADDR[i], 32'h0, r_data, r_err, r_lat, r_stall, r_zero, r_tail);
            total++;
            if (r_data !== LANE_EXP[i] || r_err !== 1'b0) begin
                bad++;
                $display("[TB] FAIL lane_load%0d: got %h err %0b expected %h err 0", i, r_data, r_err, LANE_EXP[i]);
            end
        end
        ref_access(1'b1, 3'b001, 32'h16, 32'hFFFF1234, e_err, e_data);
        do_req(1'b1, 3'b001, 32'h16, 32'hFFFF1234, r_data, r_err, r_lat, r_stall, r_zero, r_tail);
        ref_access(1'b0, 3'b101, 32'h16, 32'h0, e_err, e_data);
        do_req(1'b0, 3'b101, 32'h16, 32'h0, r_data, r_err, r_lat, r_stall, r_zero, r_tail);
        total++; if (r_data !== 32'h00001234) begin bad++; $display("[TB] FAIL sh_lhu: got %h expected 00001234", r_data); end
        ref_access(1'b0, 3'b010, 32'h14, 32'h0, e_err, e_data);
        do_req(1'b0, 3'b010, 32'h14, 32'h0, r_data, r_err, r_lat, r_stall, r_zero, r_tail);
        total++; if (r_data !== e_data) begin bad++; $display("[TB] FAIL sh_word: got %h expected %h", r_data, e_data); end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 9; i++) begin
            ref_access(ERR_WE[i], ERR_F3[i], ERR_ADDR[i], 32'h1, e_err, e_data);
            do_req(ERR_WE[i], ERR_F3[i], ERR_ADDR[i], 32'h1, r_data, r_err, r_lat, r_stall, r_zero, r_tail);
            total++;
            if (r_err !== 1'b1 || r_data !== 32'h0 || r_lat !== 0 || r_tail !== 1'b1) begin
                bad++;
                $display("[TB] FAIL err_req%0d: got err %0b rdata %h lat %0d tail %0b expected err 1 rdata 0 lat 0 tail 1",
                         i, r_err, r_data, r_lat, r_tail);
            end
        end
        for (int w = 0; w < DEPTH; w++) begin
            ref_access(1'b0, 3'b010, 32'(4 * w), 32'h0, e_err, e_data);
            do_req(1'b0, 3'b010, 32'(4 * w), 32'h0, r_data, r_err, r_lat, r_stall, r_zero, r_tail);
            total++;
            if (r_data !== e_data) begin bad++; $display("[TB] FAIL word_unchanged%0d: got %h expected %h", w, r_data, e_data); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd;
        logic exp_ready;
        logic exp_rsp;
        wd = $urandom;
        ref_access(1'b1, 3'b010, 32'h30, wd, e_err, e_data);
        m.req_valid  = 1'b1;
        m.req_we     = 1'b1;
        m.req_funct3 = 3'b010;
        m.req_addr   = 32'h30;
        m.req_wdata  = wd;
        @(posedge clk); #1;
        m.req_we = 1'b0;
        for (int j = 0; j <= 2*WS + 5; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            exp_ready = (j == WS + 2) || (j == 2*WS + 5);
            exp_rsp   = (j == WS + 1) || (j == 2*WS + 4);
            total++; if (m.req_ready !== exp_ready) begin bad++; $display("[TB] FAIL b2b_ready@%0d: got %0b expected %0b", j, m.req_ready, exp_ready); end
            total++; if (busy !== !exp_ready) begin bad++; $display("[TB] FAIL b2b_busy@%0d: got %0b expected %0b", j, busy, !exp_ready); end
            total++; if (m.rsp_valid !== exp_rsp) begin bad++; $display("[TB] FAIL b2b_rsp@%0d: got %0b expected %0b", j, m.rsp_valid, exp_rsp); end
            if (j == WS + 3) m.req_valid = 1'b0;
            if (j == 2*WS + 4) begin
                total++; if (m.rsp_rdata !== wd) begin bad++; $display("[TB] FAIL b2b_rdata: got %h expected %h", m.rsp_rdata, wd); end
            end
        end
    endtask

    task automatic test_reset_during_wait();
        ref_access(1'b1, 3'b010, 32'h20, 32'h0000CAFE, e_err, e_data);
        do_req(1'b1, 3'b010, 32'h20, 32'h0000CAFE, r_data, r_err, r_lat, r_stall, r_zero, r_tail);
        m.req_valid  = 1'b1;
        m.req_we     = 1'b1;
        m.req_funct3 = 3'b010;
        m.req_addr   = 32'h20;
        m.req_wdata  = 32'h12345678;
        @(posedge clk); #1;
        m.req_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL wait_busy: got %0b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL async_busy: got %0b expected 0", busy); end
        total++; if (m.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL async_ready: got %0b expected 1", m.req_ready); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m.req_valid  = 1'b1;
        m.req_we     = 1'b0;
        m.req_funct3 = 3'b010;
        m.req_addr   = 32'h22;
        @(posedge clk); #1;
        m.req_valid = 1'b0;
        total++; if (m.rsp_valid !== 1'b1 || m.rsp_err !== 1'b1) begin bad++; $display("[TB] FAIL err_resp: got valid %0b err %0b expected 1 1", m.rsp_valid, m.rsp_err); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (m.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL async_rsp_valid: got %0b expected 0", m.rsp_valid); end
        total++; if (m.rsp_err !== 1'b0) begin bad++; $display("[TB] FAIL async_rsp_err: got %0b expected 0", m.rsp_err); end
        @(negedge clk);
        rst_n = 1'b1;
        ref_access(1'b0, 3'b010, 32'h20, 32'h0, e_err, e_data);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, r_data, r_err, r_lat, r_stall, r_zero, r_tail);
        total++; if (r_data !== 32'h0000CAFE) begin bad++; $display("[TB] FAIL abandoned_store: got %h expected 0000cafe", r_data); end
    endtask

    task automatic test_random();
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        for (int n = 0; n < 250; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) f3 = LEGAL_F3[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) addr = ($urandom_range(0, 1) == 0) ? 32'(NBYTE + $urandom_range(0, 4000)) : $urandom;
            else addr = 32'($urandom_range(0, NBYTE - 1));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) addr[0] = 1'b0;
                if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            end
            wd = $urandom;
            ref_access(we, f3, addr, wd, e_err, e_data);
            do_req(we, f3, addr, wd, r_data, r_err, r_lat, r_stall, r_zero, r_tail);
            total++; if (r_err !== e_err) begin bad++; $display("[TB] FAIL rnd_err#%0d: got %0b expected %0b", n, r_err, e_err); end
            total++; if (r_data !== e_data) begin bad++; $display("[TB] FAIL rnd_rdata#%0d: got %h expected %h", n, r_data, e_data); end
            total++; if (r_lat !== (e_err ? 0 : WS + 1)) begin bad++; $display("[TB] FAIL rnd_latency#%0d: got %0d expected %0d", n, r_lat, e_err ? 0 : WS + 1); end
            total++; if (r_stall !== 0) begin bad++; $display("[TB] FAIL rnd_stall#%0d: got %0d expected 0", n, r_stall); end
            total++; if (r_zero !== 0) begin bad++; $display("[TB] FAIL rnd_idle_rdata#%0d: got %0d expected 0", n, r_zero); end
            total++; if (r_tail !== 1'b1) begin bad++; $display("[TB] FAIL rnd_one_cycle#%0d: got %0b expected 1", n, r_tail); end
        end
    endtask

    // Zero-wait-state instance: store then a held load, acceptances three cycles apart.
    task automatic test_ws0();
        logic exp_ready;
        logic exp_rsp;
        m0.req_valid  = 1'b1;
        m0.req_we     = 1'b1;
        m0.req_funct3 = 3'b010;
        m0.req_addr   = 32'h8;
        m0.req_wdata  = 32'hA5A50F0F;
        @(posedge clk); #1;
        m0.req_we = 1'b0;
        total++; if (busy0 !== 1'b1) begin bad++; $display("[TB] FAIL ws0_busy: got %0b expected 1", busy0); end
        for (int j = 1; j <= 5; j++) begin
            @(posedge clk); #1;
            exp_ready = (j % 3 == 2);
            exp_rsp   = (j % 3 == 1);
            total++; if (m0.req_ready !== exp_ready) begin bad++; $display("[TB] FAIL ws0_ready@%0d: got %0b expected %0b", j, m0.req_ready, exp_ready); end
            total++; if (m0.rsp_valid !== exp_rsp) begin bad++; $display("[TB] FAIL ws0_rsp@%0d: got %0b expected %0b", j, m0.rsp_valid, exp_rsp); end
            if (j == 3) m0.req_valid = 1'b0;
            if (j == 4) begin
                total++; if (m0.rsp_rdata !== 32'hA5A50F0F) begin bad++; $display("[TB] FAIL ws0_rdata: got %h expected a5a50f0f", m0.rsp_rdata); end
            end
        end
    endtask

    initial begin
        m.req_valid   = 1'b0;
        m.req_we      = 1'b0;
        m.req_funct3  = 3'b000;
        m.req_addr    = 32'h0;
        m.req_wdata   = 32'h0;
        m0.req_valid  = 1'b0;
        m0.req_we     = 1'b0;
        m0.req_funct3 = 3'b000;
        m0.req_addr   = 32'h0;
        m0.req_wdata  = 32'h0;
        test_reset();
        preload();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
        test_reset_during_wait();
        test_random();
        test_ws0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
